// File: rtl/lcg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcg_pkg                                                        |
// | Purpose  : Shared types, constants and helpers for the LCG seed search.   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package lcg_pkg;

    localparam int SEED_W     = 32;
    localparam int MODULUS    = 993441;
    localparam int MULTIPLIER = 4001;
    localparam int INCREMENT  = 60211;
    localparam int MAX_LANES  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] lowest_set_bit(input logic [MAX_LANES-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] count_ones(input logic [MAX_LANES-1:0] vec);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {4'd0, vec[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcg_search_ctrl_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcg_search_ctrl_fifo                                          |
// | Purpose  : Base/mask FIFO tracking issued batches until their results.   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module lcg_search_ctrl_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;

    function automatic logic [c_PW-1:0] ptr_next(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
        end
    end

    // Read data is taken before a same-cycle push lands, so push+pop when full is safe.
    assign o_pop_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/lcg_search_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcg_search_ctrl                                               |
// | Purpose  : Issues seed batches to the lcg_lane checkers, tracks results  |
// |            and reports the lowest matching seed.                          |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module lcg_search_ctrl
    import lcg_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int LANE_LAT     = 3,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SEED_W-1:0]    seed_lo,
    input  logic [SEED_W-1:0]    seed_hi,
    output logic                 issue_valid,
    output logic [SEED_W-1:0]    issue_base,
    output logic [NUM_LANES-1:0] issue_mask,
    input  logic                 result_valid,
    input  logic [NUM_LANES-1:0] result_hits,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [SEED_W-1:0]    valid_seed,
    output logic [SEED_W:0]      seeds_checked
);

    // Never let the outstanding window be shallower than the lane pipeline.
    localparam int c_WINDOW = (MAX_INFLIGHT > LANE_LAT) ? MAX_INFLIGHT : LANE_LAT;
    localparam int c_IW     = $clog2(c_WINDOW + 1);
    localparam int c_CW     = SEED_W + 1;
    localparam int c_FW     = SEED_W + NUM_LANES;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CW-1:0]       r_cursor;
    logic [SEED_W-1:0]     r_seed_hi;
    logic [c_IW-1:0]       r_inflight;
    logic                  r_found;
    logic [SEED_W-1:0]     r_valid_seed;
    logic [c_CW-1:0]       r_seeds_checked;

    logic                  w_issue;
    logic                  w_ret;
    logic                  w_hit;
    logic                  w_room;
    logic                  w_in_range;
    logic                  w_start_ok;
    logic [NUM_LANES-1:0]  w_mask;
    logic [NUM_LANES-1:0]  w_fifo_mask;
    logic [NUM_LANES-1:0]  w_live_hits;
    logic [SEED_W-1:0]     w_fifo_base;
    logic [c_FW-1:0]       w_fifo_rd;
    logic [c_CW:0]         w_count_sum;

    assign w_in_range = (r_cursor <= {1'b0, r_seed_hi});

    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_mask
            assign w_mask[k] = ((r_cursor + c_CW'(k)) <= {1'b0, r_seed_hi});
        end
    endgenerate

    // A result with nothing outstanding is stale (e.g. straddling a reset) and dropped.
    assign w_ret       = result_valid && (r_inflight != '0);
    assign {w_fifo_mask, w_fifo_base} = w_fifo_rd;
    assign w_live_hits = result_hits & w_fifo_mask;
    assign w_hit       = w_ret && (|w_live_hits);
    assign w_room      = (r_inflight < c_IW'(c_WINDOW)) || w_ret;
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_count_sum = {1'b0, r_seeds_checked}
                       + (c_CW + 1)'(count_ones(MAX_LANES'(w_mask)));

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) w_state_nxt = (seed_lo <= seed_hi) ? SCAN : DONE;
            end
            SCAN: begin
                if (w_hit || abort || !w_in_range) w_state_nxt = DRAIN;
                else if (w_room)                   w_issue     = 1'b1;
            end
            DRAIN: begin
                if (r_inflight == '0) w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state         <= IDLE;
            r_cursor        <= '0;
            r_seed_hi       <= '0;
            r_inflight      <= '0;
            r_found         <= 1'b0;
            r_valid_seed    <= '0;
            r_seeds_checked <= '0;
        end else begin
            r_state <= w_state_nxt;

            case ({w_issue, w_ret})
                2'b10:   r_inflight <= r_inflight + c_IW'(1);
                2'b01:   r_inflight <= r_inflight - c_IW'(1);
                default: r_inflight <= r_inflight;
            endcase

            if (w_start_ok) begin
                r_cursor        <= {1'b0, seed_lo};
                r_seed_hi       <= seed_hi;
                r_found         <= 1'b0;
                r_valid_seed    <= '0;
                r_seeds_checked <= '0;
            end else begin
                if (w_issue) begin
                    r_cursor        <= r_cursor + c_CW'(NUM_LANES);
                    r_seeds_checked <= w_count_sum[c_CW] ? '1 : w_count_sum[c_CW-1:0];
                end
                // In-order returns: the first hitting batch in SCAN holds the lowest seed.
                if ((r_state == SCAN) && w_hit) begin
                    r_found      <= 1'b1;
                    r_valid_seed <= w_fifo_base
                                  + SEED_W'(lowest_set_bit(MAX_LANES'(w_live_hits)));
                end
            end
        end
    end

    lcg_search_ctrl_fifo #(
        .DEPTH (c_WINDOW),
        .WIDTH (c_FW)
    ) u_base_fifo (
        .clk         (CLK),
        .rst         (RST),
        .i_push      (w_issue),
        .i_push_data ({w_mask, r_cursor[SEED_W-1:0]}),
        .i_pop       (w_ret),
        .o_pop_data  (w_fifo_rd)
    );

    assign issue_valid   = w_issue;
    assign issue_base    = w_issue ? r_cursor[SEED_W-1:0] : '0;
    assign issue_mask    = w_issue ? w_mask : '0;
    assign busy          = (r_state == SCAN) || (r_state == DRAIN);
    assign done          = (r_state == DONE);
    assign found         = r_found;
    assign valid_seed    = r_valid_seed;
    assign seeds_checked = r_seeds_checked;

endmodule
`default_nettype wire
